sc_frogger_status: RTL
======================

# sc_frogger_status

Game-status responder on the far side of the general state machine's command interface. It conditions the raw start button into a clean one-cycle start pulse and obeys the active-low clear command. It tracks lives and level from playfield collision/arrival events, and reports each game event back to the general state machine over a req/ack handshake. The block sits between the playfield logic and the general FSM and owns all lives/level bookkeeping.

## Interface
Parameters:
- LIVES_INIT, 3, lives loaded on reset/clear/restart (1..3)
- LEVEL_MAX, 7, highest level index (fits 3 bits)
- DEBOUNCE_CYCLES, 1000000, stable-sample count for the button (20 ms at 50 MHz)

Ports:
- SC_STATEMACHINEGENERAL_CLOCK_50  in  1  system clock, 50 MHz
- SC_STATEMACHINEGENERAL_RESET_InHigh  in  1  reset, asynchronous, active-high
- clear_InLow  in  1  synchronous clear command from general FSM, active low
- startButton_InLow  in  1  raw asynchronous push button, active low
- collision_InHigh  in  1  frog hit hazard, single-cycle pulse
- arrival_InHigh  in  1  frog reached goal row, single-cycle pulse
- ack_InHigh  in  1  general FSM accepts reported event
- start_OutHigh  out  1  debounced press, one-cycle pulse
- lives_Out  out  2  remaining lives
- level_Out  out  3  current level
- event_OutHigh  out  1  event request, held until ack
- eventCode_Out  out  2  00 WIN, 01 LIFE_LOST, 10 LEVEL_UP, 11 GAME_OVER; valid only while event_OutHigh=1

## Operation
- Reset values: state IDLE, start_OutHigh 0, lives_Out LIVES_INIT, level_Out 0, event_OutHigh 0, eventCode_Out 00, debouncer idle (released).
- clear_InLow=0: highest synchronous priority. The block reloads lives/level, drops event_OutHigh, goes to IDLE and ignores all other inputs that cycle. The debouncer is not cleared.
- Button path: 2-FF synchronizer, then a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level; any bounce restarts the count. start_OutHigh pulses once on each debounced press (falling edge of the button); release produces no pulse.
- States:
  - IDLE: start pulse -> PLAY.
  - PLAY handles collision and arrival pulses:
    - collision: if lives>1, decrement lives and go to REPORT with code LIFE_LOST; if lives=1, set lives to 0 and go to REPORT with code GAME_OVER.
    - arrival: if level<LEVEL_MAX, increment level and go to REPORT with code LEVEL_UP; at LEVEL_MAX, hold level and go to REPORT with code WIN.
    - simultaneous collision+arrival: collision wins, arrival is dropped.
  - REPORT: event_OutHigh=1 with the code held stable. On ack: WIN or GAME_OVER -> OVER, otherwise -> PLAY. Collision/arrival arriving in REPORT are discarded (no queueing).
  - OVER: start pulse reloads lives=LIVES_INIT and level=0, then goes to PLAY.
- ack_InHigh outside REPORT is ignored. A start pulse in PLAY/REPORT is ignored.
- Lives never underflow, and level never exceeds LEVEL_MAX.

## Timing
- The state, lives, level, event_OutHigh and code all update on the clock edge that samples the collision/arrival pulse. event_OutHigh is therefore visible the cycle after the pulse.
- An ack sampled high drops event_OutHigh at the next edge. Minimum req duration is 1 cycle, so ack may already be high when the request rises.
- Button-to-start_OutHigh latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle.
- Asynchronous reset mid-REPORT drops event_OutHigh immediately, with no ack required.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Shared package sc_frogger_pkg holds:
  - state encoding: IDLE, PLAY, REPORT, OVER (2 bits)
  - event code constants: WIN, LIFE_LOST, LEVEL_UP, GAME_OVER
- Sub-module sc_button_debounce (synchronizer + counter + press pulse), parameterized by DEBOUNCE_CYCLES. It is reusable for the move buttons.
- Top-level block: FSM, lives/level registers, event register.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4.
- Reset then idle: after reset, lives=3, level=0, event=0; a glitchy button (low 2 cycles, high 1, low 2) produces no start pulse.
- Start and collision: button held low 10 cycles gives exactly one start_OutHigh pulse 7 cycles after the fall and state PLAY. A collision pulse then gives event=1, code 01, lives=2 next cycle; event holds until ack, then drops the cycle after.
- Game over: three collisions, each acked, give codes 01, 01, 11 and lives 2, 1, 0. Later collisions are ignored, and a start press reloads lives=3, level=0.
- Win at top level: 7 arrivals give level 7 with LEVEL_UP each time; the 8th arrival gives code 00 with level held at 7 and state OVER after ack.
- Simultaneous collision+arrival in PLAY: code 01, level unchanged. A collision during REPORT is discarded, so lives decrement only once.
- Clear and async reset: clear_InLow=0 during REPORT drops event next cycle, reloads lives/level and goes to IDLE. Async reset asserted mid-cycle zeros event_OutHigh without waiting for a clock edge.

Source files
------------

// File: rtl/sc_frogger_pkg.sv
// Shared definitions for the frogger game-status block: FSM state encoding
// and the event codes reported to the general state machine.
package sc_frogger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_REPORT = 2'b10,
        ST_OVER   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        EV_WIN       = 2'b00,
        EV_LIFE_LOST = 2'b01,
        EV_LEVEL_UP  = 2'b10,
        EV_GAME_OVER = 2'b11
    } event_e;

    // True for the events after which the game waits for a new start press.
    function automatic logic ends_game(input event_e code);
        ends_game = (code == EV_WIN) || (code == EV_GAME_OVER);
    endfunction

endpackage

// File: rtl/sc_button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-sample counter and a
// one-cycle pulse on each debounced press (active-low button).
module sc_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic srst,
    input  logic button_InLow,
    output logic press_OutHigh
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [1:0]       sync_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             db_r;
    logic             db_next_s;
    logic             press_r;
    logic             press_next_s;

    // Synchronizer, counter and debounced-level next-state logic.
    always_comb begin
        sync_next_s  = {sync_r[0], button_InLow};
        cnt_next_s   = {CNT_W{1'b0}};
        db_next_s    = db_r;
        press_next_s = 1'b0;
        if (srst) begin
            sync_next_s = 2'b11;
            db_next_s   = 1'b1;
        end else if (sync_r[1] != db_r) begin
            if (cnt_r == CNT_LAST) begin
                // Enough consecutive differing samples: adopt the new level.
                db_next_s    = sync_r[1];
                press_next_s = ~sync_r[1];
            end else begin
                cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_next_s = {CNT_W{1'b0}};
        end
    end

    // Debouncer state registers; released button is the idle level.
    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            sync_r  <= 2'b11;
            cnt_r   <= {CNT_W{1'b0}};
            db_r    <= 1'b1;
            press_r <= 1'b0;
        end else begin
            sync_r  <= sync_next_s;
            cnt_r   <= cnt_next_s;
            db_r    <= db_next_s;
            press_r <= press_next_s;
        end
    end

    assign press_OutHigh = press_r;

endmodule

// File: rtl/sc_frogger_status.sv
// Frogger game-status responder: start conditioning, lives/level bookkeeping
// and req/ack event reporting towards the general state machine.
module sc_frogger_status
    import sc_frogger_pkg::*;
#(
    parameter int LIVES_INIT      = 3,
    parameter int LEVEL_MAX       = 7,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic       SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic       clear_InLow,
    input  logic       startButton_InLow,
    input  logic       collision_InHigh,
    input  logic       arrival_InHigh,
    input  logic       ack_InHigh,
    output logic       start_OutHigh,
    output logic [1:0] lives_Out,
    output logic [2:0] level_Out,
    output logic       event_OutHigh,
    output logic [1:0] eventCode_Out
);

    localparam logic [1:0] LIVES_C = 2'(LIVES_INIT);
    localparam logic [2:0] LEVEL_C = 3'(LEVEL_MAX);

    state_e     state_r;
    state_e     state_next_s;
    logic [1:0] lives_r;
    logic [1:0] lives_next_s;
    logic [2:0] level_r;
    logic [2:0] level_next_s;
    logic       event_r;
    logic       event_next_s;
    event_e     code_r;
    event_e     code_next_s;
    logic       start_r;
    logic       start_next_s;
    logic       press_s;

    // The debouncer keeps running through a clear; only a hard reset idles it.
    sc_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_debounce (
        .SC_STATEMACHINEGENERAL_CLOCK_50    (SC_STATEMACHINEGENERAL_CLOCK_50),
        .SC_STATEMACHINEGENERAL_RESET_InHigh(SC_STATEMACHINEGENERAL_RESET_InHigh),
        .srst                               (1'b0),
        .button_InLow                       (startButton_InLow),
        .press_OutHigh                      (press_s)
    );

    // Game FSM next-state, lives/level and event request logic.
    always_comb begin
        state_next_s = state_r;
        lives_next_s = lives_r;
        level_next_s = level_r;
        event_next_s = event_r;
        code_next_s  = code_r;
        start_next_s = press_s;
        if (!clear_InLow) begin
            state_next_s = ST_IDLE;
            lives_next_s = LIVES_C;
            level_next_s = 3'd0;
            event_next_s = 1'b0;
            code_next_s  = EV_WIN;
            start_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (press_s) begin
                        state_next_s = ST_PLAY;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    // Collision has priority; a simultaneous arrival is dropped.
                    if (collision_InHigh) begin
                        state_next_s = ST_REPORT;
                        event_next_s = 1'b1;
                        if (lives_r > 2'd1) begin
                            lives_next_s = lives_r - 2'd1;
                            code_next_s  = EV_LIFE_LOST;
                        end else begin
                            lives_next_s = 2'd0;
                            code_next_s  = EV_GAME_OVER;
                        end
                    end else if (arrival_InHigh) begin
                        state_next_s = ST_REPORT;
                        event_next_s = 1'b1;
                        if (level_r < LEVEL_C) begin
                            level_next_s = level_r + 3'd1;
                            code_next_s  = EV_LEVEL_UP;
                        end else begin
                            level_next_s = level_r;
                            code_next_s  = EV_WIN;
                        end
                    end else begin
                        state_next_s = ST_PLAY;
                    end
                end
                ST_REPORT: begin
                    if (ack_InHigh) begin
                        event_next_s = 1'b0;
                        if (ends_game(code_r)) begin
                            state_next_s = ST_OVER;
                        end else begin
                            state_next_s = ST_PLAY;
                        end
                    end else begin
                        state_next_s = ST_REPORT;
                    end
                end
                ST_OVER: begin
                    if (press_s) begin
                        state_next_s = ST_PLAY;
                        lives_next_s = LIVES_C;
                        level_next_s = 3'd0;
                    end else begin
                        state_next_s = ST_OVER;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    event_next_s = 1'b0;
                end
            endcase
        end
    end

    // Game state and output registers.
    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            state_r <= ST_IDLE;
            lives_r <= LIVES_C;
            level_r <= 3'd0;
            event_r <= 1'b0;
            code_r  <= EV_WIN;
            start_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            lives_r <= lives_next_s;
            level_r <= level_next_s;
            event_r <= event_next_s;
            code_r  <= code_next_s;
            start_r <= start_next_s;
        end
    end

    assign start_OutHigh = start_r;
    assign lives_Out     = lives_r;
    assign level_Out     = level_r;
    assign event_OutHigh = event_r;
    assign eventCode_Out = code_r;

endmodule
